// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: redirect inputs, instruction-memory handshake, PC and flush outputs.
// Latency: none (wires only).
// Backpressure: imem_ready from memory stalls the outstanding request; stall_i from hazard unit.
// Ports: master = the fetch sequencer, slave = pipeline/memory environment.
interface fetch_sequencer_if;
  logic        stall_i;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if;
  logic        flush_id;
  logic        misalign_err;

  modport master (
    input  stall_i, branch_taken, branch_target, jump_valid, jump_target, imem_ready,
    output imem_req, imem_addr, pc, fetch_valid, flush_if, flush_id, misalign_err
  );

  modport slave (
    output stall_i, branch_taken, branch_target, jump_valid, jump_target, imem_ready,
    input  imem_req, imem_addr, pc, fetch_valid, flush_if, flush_id, misalign_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues imem requests, applies branch/jump redirects.
// Latency: PC updates one edge after accept or immediate redirect; flush/valid outputs are combinational.
// Backpressure: once a request is issued it is held at a fixed address until imem_ready; stall_i only gates new requests.
// Ports: clk, rst (async active-low), bus (fetch_sequencer_if.master).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redirect;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        misalign;
  logic        req;
  logic        accept;
  logic [31:0] accept_pc;

  always_comb begin
    redirect  = bus.branch_taken | bus.jump_valid;
    // Branch (older instruction, EX stage) beats jump (ID stage).
    redir_raw = bus.branch_taken ? bus.branch_target : bus.jump_target;
    redir_tgt = {redir_raw[31:2], 2'b00};
    misalign  = redirect & (redir_raw[1:0] != 2'b00);

    // A request already outstanding (WAIT) must stay up regardless of stall_i.
    req       = (state_q == WAIT) | ((state_q == REQ) & ~bus.stall_i);
    accept    = req & bus.imem_ready;
    accept_pc = redirect ? redir_tgt : (pend_vld_q ? pend_pc_q : pc_q + 32'd4);

    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;

    case (state_q)
      BOOT: state_d = REQ;
      REQ, WAIT: begin
        if (accept) begin
          pc_d       = accept_pc;
          pend_vld_d = 1'b0;
          state_d    = REQ;
        end else if (req) begin
          // Address must not move while the request is pending; park the redirect.
          state_d = WAIT;
          if (redirect) begin
            pend_pc_d  = redir_tgt;
            pend_vld_d = 1'b1;
          end
        end else if (redirect) begin
          // Nothing in flight, so the redirect can land on the PC directly.
          pc_d       = redir_tgt;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  // The instruction returned with a pending redirect is from the old path.
  assign bus.flush_if     = redirect | (accept & pend_vld_q);
  assign bus.flush_id     = bus.branch_taken;
  assign bus.fetch_valid  = accept & ~bus.flush_if;
  assign bus.misalign_err = misalign;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, whether a request is in flight, parked redirect, boot cycle.
  logic        m_boot = 1'b1;
  logic [31:0] m_pc = RESET_PC;
  logic        m_out = 1'b0;
  logic        m_pend_vld = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;

  always @(negedge clk) begin : compare
    logic        redirect, e_req, e_acc, e_fif, e_mis;
    logic [31:0] raw, tgt;
    if (!rst) begin
      m_boot     <= 1'b1;
      m_pc       <= RESET_PC;
      m_out      <= 1'b0;
      m_pend_vld <= 1'b0;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_pc", bus.pc, RESET_PC);
      chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    end else begin
      redirect = bus.branch_taken | bus.jump_valid;
      raw      = bus.branch_taken ? bus.branch_target : bus.jump_target;
      tgt      = raw & 32'hFFFF_FFFC;
      e_mis    = redirect && ((raw % 4) != 0);
      e_req    = !m_boot && (m_out || !bus.stall_i);
      e_acc    = e_req && bus.imem_ready;
      e_fif    = redirect || (e_acc && m_pend_vld);
      chk("imem_req", 32'(bus.imem_req), 32'(e_req));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("pc", bus.pc, m_pc);
      chk("flush_if", 32'(bus.flush_if), 32'(e_fif));
      chk("flush_id", 32'(bus.flush_id), 32'(bus.branch_taken));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_acc && !e_fif));
      chk("misalign_err", 32'(bus.misalign_err), 32'(e_mis));
      if (m_boot) begin
        m_boot <= 1'b0;
      end else if (e_acc) begin
        m_pc       <= redirect ? tgt : (m_pend_vld ? m_pend_pc : m_pc + 32'd4);
        m_pend_vld <= 1'b0;
        m_out      <= 1'b0;
      end else if (e_req) begin
        m_out <= 1'b1;
        if (redirect) begin
          m_pend_vld <= 1'b1;
          m_pend_pc  <= tgt;
        end
      end else if (redirect) begin
        m_pc       <= tgt;
        m_pend_vld <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic bt, input logic [31:0] btt,
                       input logic jv, input logic [31:0] jt, input logic rdy);
    bus.stall_i       = st;
    bus.branch_taken  = bt;
    bus.branch_target = btt;
    bus.jump_valid    = jv;
    bus.jump_target   = jt;
    bus.imem_ready    = rdy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (3) tick();
    chk("lit_reset_pc", bus.pc, 32'h0);
    rst = 1'b1;

    // Boot cycle, then sequential fetch from RESET_PC.
    look(); chk("lit_boot_req", 32'(bus.imem_req), 32'd0);
    look(); chk("lit_addr0", bus.imem_addr, 32'h0); chk("lit_fv0", 32'(bus.fetch_valid), 32'd1);
    look(); chk("lit_addr4", bus.imem_addr, 32'h4);
    look(); chk("lit_addr8", bus.imem_addr, 32'h8);

    // Stall plus redirect: redirect lands, no request.
    tick(); drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    look(); chk("lit_stall_redir_req", 32'(bus.imem_req), 32'd0);
    // Memory not ready for three cycles with stall toggling.
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(); chk("lit_hold_a", bus.imem_addr, 32'h10);
    tick(); bus.stall_i = 1'b1;
    look(); chk("lit_hold_b_req", 32'(bus.imem_req), 32'd1); chk("lit_hold_b", bus.imem_addr, 32'h10);
    tick(); bus.stall_i = 1'b0;
    look(); chk("lit_hold_c", bus.imem_addr, 32'h10);
    tick(); bus.stall_i = 1'b1; bus.imem_ready = 1'b1;
    look(); chk("lit_hold_acc_req", 32'(bus.imem_req), 32'd1); chk("lit_hold_acc_fv", 32'(bus.fetch_valid), 32'd1);
    tick(); bus.stall_i = 1'b0;
    look(); chk("lit_adv_14", bus.pc, 32'h14);

    // Branch and jump on the same accept: branch wins.
    tick(); drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    look(); chk("lit_bj_flush_if", 32'(bus.flush_if), 32'd1);
    chk("lit_bj_flush_id", 32'(bus.flush_id), 32'd1);
    chk("lit_bj_fv", 32'(bus.fetch_valid), 32'd0);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    look(); chk("lit_bj_pc", bus.pc, 32'h200);

    // Jump arriving while waiting at 0x20.
    tick(); drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(); chk("lit_wait_addr", bus.imem_addr, 32'h20);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(); chk("lit_wait_hold", bus.imem_addr, 32'h20);
    tick(); bus.imem_ready = 1'b1;
    look(); chk("lit_pend_flush_if", 32'(bus.flush_if), 32'd1); chk("lit_pend_fv", 32'(bus.fetch_valid), 32'd0);
    tick();
    look(); chk("lit_pend_pc", bus.pc, 32'h40);

    // PC wrap and misaligned branch target.
    tick(); drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    look(); chk("lit_top_pc", bus.pc, 32'hFFFF_FFFC);
    tick();
    look(); chk("lit_wrap_pc", bus.pc, 32'h0);
    tick(); drive(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
    look(); chk("lit_misalign", 32'(bus.misalign_err), 32'd1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    look(); chk("lit_align_pc", bus.pc, 32'h100); chk("lit_misalign_end", 32'(bus.misalign_err), 32'd0);

    // Reset while waiting at 0x80.
    tick(); drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    look(); chk("lit_w80_req", 32'(bus.imem_req), 32'd1); chk("lit_w80_addr", bus.imem_addr, 32'h80);
    rst = 1'b0;
    #1;
    chk("lit_arst_req", 32'(bus.imem_req), 32'd0);
    chk("lit_arst_pc", bus.pc, RESET_PC);
    tick(); bus.imem_ready = 1'b1;
    tick(); rst = 1'b1;
    look(); chk("lit_reboot_req", 32'(bus.imem_req), 32'd0);
    look(); chk("lit_restart_req", 32'(bus.imem_req), 32'd1); chk("lit_restart_addr", bus.imem_addr, RESET_PC);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
      end
      drive($urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) < 6);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  hazard-unit stall; hold PC, issue no new request.
REQ-005 branch_taken  input  1  EX-stage taken branch redirect.
REQ-006 branch_target  input  32  branch destination.
REQ-007 jump_valid  input  1  ID-stage JAL/JALR redirect.
REQ-008 jump_target  input  32  jump destination.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; equals pc.
REQ-011 imem_ready  input  1  memory accepts request and returns instruction this cycle.
REQ-012 pc  output  32  current fetch PC (registered).
REQ-013 fetch_valid  output  1  returned instruction is on the correct path; IF/ID may capture it.
REQ-014 flush_if  output  1  kill instruction in IF/ID.
REQ-015 flush_id  output  1  kill instruction in ID/EX.
REQ-016 misalign_err  output  1  single-cycle pulse: applied target had bits[1:0] != 0.

Function
REQ-017 FSM states SHALL be BOOT, REQ, WAIT, encoded in a registered state variable.
REQ-018 BOOT: imem_req=0; unconditional transition to REQ next cycle.
REQ-019 REQ: imem_req = !stall_i; req&ready -> advance PC, stay REQ; req&!ready -> WAIT; no req -> stay REQ, PC held.
REQ-020 WAIT: imem_req=1 regardless of stall_i; ready -> advance PC, go REQ; else stay WAIT.
REQ-021 Handshake: while imem_req=1 and imem_ready=0, imem_addr SHALL stay constant until acceptance.
REQ-022 "Accept" = imem_req & imem_ready; PC updates only on accept or on an immediate redirect (REQ-024).
REQ-023 Next-PC priority on accept: branch_taken > jump_valid > pending redirect > pc+4.
REQ-024 Redirect while no request is outstanding (REQ state, imem_req=0): PC <= target next edge, pending unaffected except cleared.
REQ-025 Redirect while imem_req=1 and imem_ready=0: target captured into pending register (branch over jump); newer redirect overwrites older pending.
REQ-026 Pending redirect SHALL be consumed and cleared on the next accept; that accept's instruction is wrong-path.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 Applied targets SHALL have bits[1:0] forced to 0; misalign_err pulses the same cycle the target is presented.
REQ-029 flush_if = branch_taken | jump_valid | (accept & pending valid); combinational.
REQ-030 flush_id = branch_taken; combinational.
REQ-031 fetch_valid = accept & !flush_if.
REQ-032 stall_i and redirect in same cycle in REQ: redirect wins, PC loads target, no request issued.

Reset
REQ-033 rst low SHALL asynchronously force state=BOOT, pc=RESET_PC, pending cleared, imem_req=0, fetch_valid=0.
REQ-034 Reset asserted mid-WAIT SHALL abandon the outstanding request; no PC update on release.
REQ-035 First request SHALL issue in the second cycle after rst deasserts, at RESET_PC.

Verification
REQ-036 Reset release, imem_ready=1, no stall -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles, fetch_valid=1 each.
REQ-037 imem_ready=0 for 3 cycles at pc=0x10 with stall_i toggling -> imem_req=1, imem_addr=0x10 held; advances to 0x14 on ready.
REQ-038 branch_taken=1, target 0x200, jump_valid=1, target 0x300, same accept cycle -> pc=0x200, flush_if=1, flush_id=1, fetch_valid=0.
REQ-039 jump_valid target 0x40 during WAIT at 0x20, ready 2 cycles later -> pc=0x40 after accept, flush_if=1 at accept, fetch_valid=0.
REQ-040 pc=0xFFFF_FFFC accepted -> pc=0x0000_0000; branch target 0x102 -> pc=0x100, misalign_err pulses 1 cycle.
REQ-041 rst asserted during WAIT at 0x80 -> imem_req=0 immediately, pc=RESET_PC, fetch restarts at RESET_PC per REQ-035.
